// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: stall vector layout,
// stall masks, redirect FSM encoding and common constants.
package pipe_ctrl_pkg;

    // Bit positions inside the stall vector, one per pipeline register
    localparam int STALL_PC_BIT  = 0;
    localparam int STALL_IF_BIT  = 1;
    localparam int STALL_ID_BIT  = 2;
    localparam int STALL_EX_BIT  = 3;
    localparam int STALL_MEM_BIT = 4;
    localparam int STALL_WB_BIT  = 5;
    localparam int STALL_W       = STALL_WB_BIT + 1;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam logic [STALL_W-1:0] STALL_NONE = {STALL_W{NO_STOP}};

    // A stalling stage freezes itself and every register upstream of it
    localparam logic [STALL_W-1:0] STALL_MASK_IF  = STALL_NONE
                                                  | (6'(STOP) << STALL_PC_BIT)
                                                  | (6'(STOP) << STALL_IF_BIT);
    localparam logic [STALL_W-1:0] STALL_MASK_ID  = STALL_MASK_IF | (6'(STOP) << STALL_ID_BIT);
    localparam logic [STALL_W-1:0] STALL_MASK_EX  = STALL_MASK_ID | (6'(STOP) << STALL_EX_BIT);
    localparam logic [STALL_W-1:0] STALL_MASK_MEM = STALL_MASK_EX | (6'(STOP) << STALL_MEM_BIT);

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_FLUSH  = 2'b01,
        ST_REFILL = 2'b10
    } ctrl_state_e;

endpackage

// File: rtl/pipe_ctrl_stall_wdog.sv
// Stall watchdog: counts consecutive stalled cycles and raises a sticky
// timeout flag once the count reaches WDOG_CYCLES. The counter saturates.
module stall_wdog #(
    parameter int WDOG_CYCLES = 1024
) (
    input  logic clk_i,
    input  logic n_rst_i,
    input  logic stall_any_i,
    output logic timeout_o
);

    localparam logic [15:0] LIMIT = 16'(WDOG_CYCLES);

    logic [15:0] cnt_r;
    logic [15:0] cnt_nxt_s;
    logic        timeout_r;

    // Next count: clear when the pipe moves, count up to the limit and hold
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (!stall_any_i) begin
            cnt_nxt_s = 16'd0;
        end else if (cnt_r != LIMIT) begin
            cnt_nxt_s = cnt_r + 16'd1;
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Counter register and sticky timeout flag
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            cnt_r     <= 16'd0;
            timeout_r <= 1'b0;
        end else begin
            cnt_r <= cnt_nxt_s;
            if (cnt_nxt_s == LIMIT) begin
                timeout_r <= 1'b1;
            end else begin
                timeout_r <= timeout_r;
            end
        end
    end

    assign timeout_o = timeout_r;

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline controller: merges stage stall requests, sequences
// trap/mret redirects (flush + PC load, then a refill window) with a
// one-deep pending latch, and hosts the stall watchdog.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REFILL_CYCLES = 2,
    parameter int WDOG_CYCLES   = 1024
) (
    input  logic         clk_i,
    input  logic         n_rst_i,
    input  logic         stallreq_if_i,
    input  logic         stallreq_id_i,
    input  logic         stallreq_ex_i,
    input  logic         stallreq_mem_i,
    input  logic         trap_i,
    input  logic [31:0]  trap_vec_i,
    input  logic         mret_i,
    input  logic [31:0]  epc_i,
    output logic [5:0]   stall_o,
    output logic         flush_o,
    output logic         pc_load_o,
    output logic [31:0]  new_pc_o,
    output logic         busy_o,
    output logic         overrun_o,
    output logic         stall_timeout_o
);

    localparam logic [3:0] REFILL_LOAD = 4'(REFILL_CYCLES - 1);

    ctrl_state_e         state_r, state_nxt_s;
    logic [3:0]          refill_cnt_r, refill_cnt_nxt_s;
    logic                pend_vld_r, pend_vld_nxt_s;
    logic [31:0]         pend_pc_r, pend_pc_nxt_s;
    logic [31:0]         new_pc_r, new_pc_nxt_s;
    logic                overrun_r, overrun_nxt_s;
    logic                flush_r;
    logic                busy_r;
    logic                req_s;
    logic [31:0]         req_pc_s;
    logic [STALL_W-1:0]  stall_s;
    logic                stall_any_s;

    // Redirect request and its target; a trap outranks a simultaneous mret
    always_comb begin
        req_s = trap_i | mret_i;
        if (trap_i) begin
            req_pc_s = trap_vec_i;
        end else begin
            req_pc_s = epc_i;
        end
    end

    // Stall merge: deepest requesting stage wins; a flush lets everything move
    always_comb begin
        stall_s = STALL_NONE;
        if (flush_r) begin
            stall_s = STALL_NONE;
        end else if (stallreq_mem_i) begin
            stall_s = STALL_MASK_MEM;
        end else if (stallreq_ex_i) begin
            stall_s = STALL_MASK_EX;
        end else if (stallreq_id_i) begin
            stall_s = STALL_MASK_ID;
        end else if (stallreq_if_i) begin
            stall_s = STALL_MASK_IF;
        end else begin
            stall_s = STALL_NONE;
        end
        stall_any_s = (stall_s != STALL_NONE);
    end

    // Redirect sequencer: next state, pending latch, target and overrun
    always_comb begin
        state_nxt_s      = state_r;
        refill_cnt_nxt_s = refill_cnt_r;
        pend_vld_nxt_s   = pend_vld_r;
        pend_pc_nxt_s    = pend_pc_r;
        new_pc_nxt_s     = new_pc_r;
        overrun_nxt_s    = overrun_r;
        case (state_r)
            ST_IDLE: begin
                if (pend_vld_r) begin
                    // Deferred redirect first; a new request refills the latch
                    state_nxt_s    = ST_FLUSH;
                    new_pc_nxt_s   = pend_pc_r;
                    pend_vld_nxt_s = req_s;
                    pend_pc_nxt_s  = req_s ? req_pc_s : pend_pc_r;
                end else if (req_s) begin
                    state_nxt_s  = ST_FLUSH;
                    new_pc_nxt_s = req_pc_s;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                state_nxt_s      = ST_REFILL;
                refill_cnt_nxt_s = REFILL_LOAD;
                if (req_s && !pend_vld_r) begin
                    pend_vld_nxt_s = 1'b1;
                    pend_pc_nxt_s  = req_pc_s;
                end else if (req_s) begin
                    overrun_nxt_s = 1'b1;
                end else begin
                    pend_vld_nxt_s = pend_vld_r;
                end
            end
            ST_REFILL: begin
                if (req_s && !pend_vld_r) begin
                    pend_vld_nxt_s = 1'b1;
                    pend_pc_nxt_s  = req_pc_s;
                end else if (req_s) begin
                    overrun_nxt_s = 1'b1;
                end else begin
                    pend_vld_nxt_s = pend_vld_r;
                end
                if (refill_cnt_r != 4'd0) begin
                    state_nxt_s      = ST_REFILL;
                    refill_cnt_nxt_s = refill_cnt_r - 4'd1;
                end else if (pend_vld_r) begin
                    // Back-to-back: go straight into the deferred flush
                    state_nxt_s    = ST_FLUSH;
                    new_pc_nxt_s   = pend_pc_r;
                    pend_vld_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Sequencer state and registered outputs
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            state_r      <= ST_IDLE;
            refill_cnt_r <= 4'd0;
            pend_vld_r   <= 1'b0;
            pend_pc_r    <= ZERO_WORD;
            new_pc_r     <= ZERO_WORD;
            overrun_r    <= 1'b0;
            flush_r      <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            refill_cnt_r <= refill_cnt_nxt_s;
            pend_vld_r   <= pend_vld_nxt_s;
            pend_pc_r    <= pend_pc_nxt_s;
            new_pc_r     <= new_pc_nxt_s;
            overrun_r    <= overrun_nxt_s;
            flush_r      <= (state_nxt_s == ST_FLUSH);
            busy_r       <= (state_nxt_s != ST_IDLE);
        end
    end

    stall_wdog #(
        .WDOG_CYCLES (WDOG_CYCLES)
    ) u_stall_wdog (
        .clk_i       (clk_i),
        .n_rst_i     (n_rst_i),
        .stall_any_i (stall_any_s),
        .timeout_o   (stall_timeout_o)
    );

    assign stall_o   = stall_s;
    assign flush_o   = flush_r;
    assign pc_load_o = flush_r;
    assign new_pc_o  = new_pc_r;
    assign busy_o    = busy_r;
    assign overrun_o = overrun_r;

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central pipeline controller for the five-stage core. It merges per-stage stall requests into the 6-bit `stall_o` vector consumed by the pc, if_id, id_ex, ex_mem and mem_wb registers. It sequences trap/return redirects as a registered flush pulse plus PC load, followed by a refill window. It also runs a stall watchdog. It sits beside the ifu and feeds `stall_i`/`flush_i` of every pipeline register.

## Interface
Parameters:
- `REFILL_CYCLES`, default 2: cycles after a flush during which new redirects are deferred (1..15).
- `WDOG_CYCLES`, default 1024: consecutive stalled cycles before the watchdog fires (2..65535).

Ports:
- `clk_i` in 1: the single clock.
- `n_rst_i` in 1: reset, asynchronous and active-low.
- `stallreq_if_i` in 1: fetch waiting on instruction rom/bus.
- `stallreq_id_i` in 1: load-use hazard.
- `stallreq_ex_i` in 1: multi-cycle mul/div busy.
- `stallreq_mem_i` in 1: data bus wait.
- `trap_i` in 1: exception/interrupt committed at mem stage.
- `trap_vec_i` in 32: handler address, valid with `trap_i`.
- `mret_i` in 1: return-from-trap committed.
- `epc_i` in 32: return address, valid with `mret_i`.
- `stall_o` out 6: bit0 pc, 1 if, 2 id, 3 ex, 4 mem, 5 wb; 1 = stop.
- `flush_o` out 1: flush all pipeline registers.
- `pc_load_o` out 1: ifu loads `new_pc_o`.
- `new_pc_o` out 32: redirect target.
- `busy_o` out 1: FSM not in IDLE.
- `overrun_o` out 1: sticky; a redirect was dropped.
- `stall_timeout_o` out 1: sticky watchdog flag.

## Operation
- Stall merge is combinational and picks the highest-priority request:
  - mem: `6'b011111`
  - ex: `6'b001111`
  - id: `6'b000111`
  - if: `6'b000011`
  - none: `6'b000000`
- While `flush_o`=1, `stall_o` is forced to 0.
- Redirect request: `trap_i` or `mret_i`. `trap_i` wins when both are high; the target is `trap_vec_i`, otherwise `epc_i`.
- FSM states: IDLE, FLUSH, REFILL.
  - IDLE to FLUSH: on a request, or when the pending latch is set. The target is captured into `new_pc_o`.
  - FLUSH to REFILL: always, after exactly 1 cycle. In FLUSH, `flush_o`=`pc_load_o`=1.
  - REFILL to IDLE: when the down-counter (loaded with `REFILL_CYCLES`-1) reaches 0.
- Pending latch:
  - A request arriving in FLUSH or REFILL is stored, target included, when the latch is empty.
  - If the latch is already full, the request is dropped and `overrun_o` is set.
  - The pending request is served in priority over a new request in the same IDLE cycle. That simultaneous new request goes to the latch, or counts as an overrun if the latch stays full.
- Watchdog:
  - A 16-bit counter increments while `stall_o`≠0 and clears when `stall_o`=0.
  - When it reaches `WDOG_CYCLES`, `stall_timeout_o` sets and stays set until reset. The counter saturates.

## Timing
- All outputs reset to 0, and the FSM resets to IDLE, asynchronously. The pending latch and counters clear.
- `stall_o` has zero latency from the requests.
- Redirect sampled at edge N:
  - `flush_o`/`pc_load_o`/`new_pc_o` are valid in cycle N+1, for one cycle only.
  - `busy_o` is high for cycles N+1 .. N+1+`REFILL_CYCLES`.
- Back-to-back: a pending redirect gives its next flush at cycle N+2+`REFILL_CYCLES`.
- `new_pc_o` holds its last value outside FLUSH.
- Reset mid-sequence abandons the redirect and any pending request.

## Structure
- Shared package/defines:
  - stall bit positions
  - `Stop`/`NO_STOP`
  - the four stall masks
  - FSM state encodings
  - `ZERO_WORD`
- One sub-module, `stall_wdog` (counter plus sticky flag).
- The remaining logic is inline.

## Test plan
- `stallreq_id_i`=1 with `stallreq_mem_i`=1 → `stall_o`=`6'b011111`. `stallreq_if_i` alone → `6'b000011`.
- `trap_i` with `trap_vec_i`=0x80000100 at edge N → `flush_o`=`pc_load_o`=1 and `new_pc_o`=0x80000100 in N+1 only; `busy_o` high N+1..N+3 (REFILL_CYCLES=2).
- `trap_i` and `mret_i` simultaneous (epc 0x1000) → target = `trap_vec_i`; no second flush.
- `mret_i` at N+2 during REFILL → a second flush to `epc_i` at N+4. A third request at N+3 → dropped and `overrun_o`=1.
- `stallreq_ex_i` held 1024 cycles (WDOG_CYCLES=1024) → `stall_timeout_o` rises exactly at the 1024th stalled cycle; releasing the stall does not clear it.
- `n_rst_i` low during FLUSH → all outputs 0 immediately; after release, no flush occurs without a new request.
